buf_out_ctrl: RTL
=================

# buf_out_ctrl

Output-buffer controller of the resizer. It owns the circular entry store between the packing stage and `master`: it accepts packed output entries from the packer, presents the oldest entry to `master` as `master_entry`, and drives `underflow`. It also exports occupancy, full/overflow and a count of buffered packet ends, so upstream scheduling can throttle the packer.

## Interface
Parameters:
- `M_KEEP_WIDTH`, 2: output lanes per entry.
- `T_DATA_WIDTH`, 1: data bits per lane.
- `DEPTH`, 8: entries in the store; must be a power of two, at least 2.
- `BUF_OUT_ENTRY_SZ`, `(2+T_DATA_WIDTH)*M_KEEP_WIDTH`: entry width. Lane i occupies bits `[i*(T_DATA_WIDTH+2) +: T_DATA_WIDTH+2]`, laid out as `{keep, last, data}` with keep as the MSB.
- `CNT_W`, `$clog2(DEPTH+1)`: width of the counters.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active high.
- `wr_valid`, in, 1: the packer offers an entry.
- `wr_entry`, in, `BUF_OUT_ENTRY_SZ`: the offered entry.
- `wr_ready`, out, 1: a slot is available. Reset 1.
- `overflow`, out, 1: sticky flag, set when `wr_valid` is high while `wr_ready` is low. Reset 0.
- `clr_overflow`, in, 1: clears `overflow`.
- `master_entry`, out, `BUF_OUT_ENTRY_SZ`: head entry, first-word-fall-through. Reset all zeros.
- `underflow`, out, 1: store empty; `master_entry` is invalid. Reset 1.
- `master_entry_ready`, in, 1: `master` has consumed the head entry (pop).
- `level`, out, `CNT_W`: entries currently stored. Reset 0.
- `pkt_count`, out, `CNT_W`: stored entries with at least one lane `last` bit set. Reset 0.

## Operation
- Storage is a circular array of DEPTH entries with write and read pointers of `$clog2(DEPTH)` bits. Pointers wrap from DEPTH-1 to 0.
- Push occurs when `wr_valid && wr_ready`. The entry is written at `wptr` and `wptr` increments.
- Pop occurs when `master_entry_ready && !underflow`. `rptr` increments. A pop while `underflow` is high is ignored: pointers and counters do not change.
- `level` is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `pkt_count` follows the same rule. The increment applies when the pushed entry has any `last` bit set. The decrement applies when the popped head has any `last` bit set.
- `wr_ready = (level != DEPTH)`.
- When full, a simultaneous pop does not raise `wr_ready` in the same cycle. The push is refused and `overflow` sets if `wr_valid` is high.
- `underflow = (level == 0)`.
- `overflow` set and clear:
  - It sets on any cycle with `wr_valid && !wr_ready`.
  - `clr_overflow` clears it.
  - If set and clear occur in the same cycle, set wins.
- Reset clears the pointers, `level`, `pkt_count` and `overflow` at once, including in the middle of a packet. Stored contents are discarded. `master_entry` reads zeros until the first push after reset.

## Timing
- Push to visible: an entry pushed at edge N appears on `master_entry` with `underflow` = 0 after edge N, i.e. 1 cycle of latency.
- There is no combinational path from `wr_valid` to `underflow`/`master_entry`, or from `master_entry_ready` to `wr_ready`.
- `master_entry` changes only after a pop, or after a push into an empty store. It is stable while `underflow` = 0 and no pop occurs.
- Push and pop can both occur every cycle. With DEPTH ≥ 2, sustained throughput is 1 entry per cycle, with `level` constant.
- Outputs are derived from registered state only. `master_entry` is a registered head register, or a registered read port that is looked ahead on pop.
- The empty case with push and pop in the same cycle is a pop-ignored case: the entry is stored and `level` becomes 1.

## Structure
- Shared package `resizer_pkg` holds:
  - lane field offsets: `LANE_KEEP`, `LANE_LAST`, data LSB;
  - a function `entry_sz(m_keep, t_data)`;
  - a function `entry_has_last(entry)`, which is the OR of the lane `last` bits.
- One sub-module, `buf_ram`: a simple dual-port DEPTH×`BUF_OUT_ENTRY_SZ` array with one synchronous write port and one read port. The pointer/counter logic stays in `buf_out_ctrl`.

## Test plan
- Reset and idle: hold `rst` for 2 cycles → `underflow`=1, `wr_ready`=1, `level`=0, `pkt_count`=0, `overflow`=0, `master_entry`=0. Pop with the store empty → no change.
- Single entry (M=2, T=1): push 6'b101100 → next cycle `master_entry`=6'b101100, `underflow`=0, `level`=1, `pkt_count`=0. Pop → `underflow`=1, `level`=0.
- Packet tracking: push 6'b101101, then 6'b110000 (lane1 last) → `pkt_count`=1, `level`=2. Pop twice → order preserved, `pkt_count`=0 after the second pop.
- Fill and wrap: push 8 entries with values 0..7 into DEPTH=8 → `wr_ready`=0. A 9th push → refused, `overflow`=1 and it stays set. Pop 3, push 3 (values 8..10) → reads return 3..10 in order across the pointer wrap. `clr_overflow` → 0.
- Full boundary: with the store full, assert push and pop together → pop accepted, push refused, `level`=7, `overflow`=1.
- Streaming and mid-run reset: push and pop every cycle for 20 cycles → `level` constant at 1, data in order. Assert `rst` mid-stream → the next cycle shows `level`=0, `pkt_count`=0, `underflow`=1.

Source files
------------

// File: rtl/resizer_pkg.sv
// resizer_pkg: shared definitions for the resizer output path.
// Lane layout inside an entry, lane i at [i*(T+2) +: T+2]: {keep, last, data}.
// Data sits at LANE_DATA_LSB. The last and keep bits are given as offsets above
// the data field, so lane bit = i*(T+2) + T + LANE_LAST / LANE_KEEP.
package resizer_pkg;

  localparam int LANE_DATA_LSB = 0;
  localparam int LANE_LAST     = 0;
  localparam int LANE_KEEP     = 1;

  // Widest entry the helper functions accept; callers zero-extend.
  localparam int ENTRY_MAX_W   = 1024;

  function automatic int entry_sz(input int m_keep, input int t_data);
    return (2 + t_data) * m_keep;
  endfunction

  // OR of every lane's last bit.
  function automatic logic entry_has_last(input logic [ENTRY_MAX_W-1:0] entry,
                                          input int m_keep, input int t_data);
    logic r;
    r = 1'b0;
    for (int i = 0; i < m_keep; i++)
      r = r | entry[i*(t_data+2) + t_data + LANE_LAST];
    return r;
  endfunction

endpackage

// File: rtl/buf_ram.sv
// buf_ram: DEPTH x W simple dual-port store.
// Ports: clk; i_we/i_waddr/i_wdata synchronous write; i_raddr/o_rdata
// asynchronous read of the registered array.
module buf_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/buf_out_ctrl.sv
// buf_out_ctrl: circular output-entry store between the packer and master.
// Ports:
//   clk, rst (sync, active high)
//   wr_valid/wr_entry/wr_ready : push side from the packer
//   overflow/clr_overflow      : sticky refused-push flag and its clear
//   master_entry/underflow     : first-word-fall-through head, empty flag
//   master_entry_ready         : pop of the head
//   level/pkt_count            : occupancy and entries holding a packet end
module buf_out_ctrl
  import resizer_pkg::*;
#(
  parameter int M_KEEP_WIDTH     = 2,
  parameter int T_DATA_WIDTH     = 1,
  parameter int DEPTH            = 8,
  parameter int BUF_OUT_ENTRY_SZ = entry_sz(M_KEEP_WIDTH, T_DATA_WIDTH),
  parameter int CNT_W            = $clog2(DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [BUF_OUT_ENTRY_SZ-1:0] wr_entry,
  output logic                        wr_ready,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [BUF_OUT_ENTRY_SZ-1:0] master_entry,
  output logic                        underflow,
  input  logic                        master_entry_ready,
  output logic [CNT_W-1:0]            level,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0] r_level, r_pkt;
  logic             r_ovf;

  logic                        w_push, w_pop;
  logic [BUF_OUT_ENTRY_SZ-1:0] w_head;
  logic [ENTRY_MAX_W-1:0]      w_wr_ext, w_head_ext;
  logic                        w_wr_last, w_head_last;

  // Flags come from the registered level only, so a pop never frees a slot
  // for a push in the same cycle and a push is never popped the cycle it lands.
  assign wr_ready  = (r_level != CNT_W'(DEPTH));
  assign underflow = (r_level == '0);
  assign w_push    = wr_valid && wr_ready;
  assign w_pop     = master_entry_ready && !underflow;

  buf_ram #(.DEPTH(DEPTH), .W(BUF_OUT_ENTRY_SZ), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (wr_entry),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  // Stale array contents survive reset; mask them while empty.
  assign master_entry = underflow ? '0 : w_head;

  always_comb begin
    w_wr_ext   = '0;
    w_head_ext = '0;
    w_wr_ext[BUF_OUT_ENTRY_SZ-1:0]   = wr_entry;
    w_head_ext[BUF_OUT_ENTRY_SZ-1:0] = w_head;
  end

  assign w_wr_last   = entry_has_last(w_wr_ext, M_KEEP_WIDTH, T_DATA_WIDTH);
  assign w_head_last = entry_has_last(w_head_ext, M_KEEP_WIDTH, T_DATA_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_pkt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + CNT_W'(1);
        2'b01:   r_level <= r_level - CNT_W'(1);
        default: r_level <= r_level;
      endcase
      r_pkt <= r_pkt + CNT_W'(w_push && w_wr_last) - CNT_W'(w_pop && w_head_last);
      // Set dominates clear.
      if (wr_valid && !wr_ready) r_ovf <= 1'b1;
      else if (clr_overflow)     r_ovf <= 1'b0;
    end
  end

  assign level     = r_level;
  assign pkt_count = r_pkt;
  assign overflow  = r_ovf;

endmodule
